// File: rtl/rdma_rc_qp_ctx_mgr.sv
// Multi-QP RC context manager: NUM_QP independent QP state machines behind
// one valid/ready command port with a registered, backpressurable response.
module rdma_rc_qp_ctx_mgr #(
    parameter int unsigned NUM_QP      = 8,
    parameter int unsigned IDX_WIDTH   = 3,
    parameter int unsigned QPN_WIDTH   = 16,
    parameter int unsigned PSN_WIDTH   = 24,
    parameter int unsigned MAX_RETRY   = 7,
    parameter int unsigned RETRY_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [IDX_WIDTH-1:0]   cmd_idx,
    input  logic [2:0]             cmd_op,
    input  logic [QPN_WIDTH-1:0]   cmd_qpn,
    input  logic [PSN_WIDTH-1:0]   cmd_psn,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDX_WIDTH-1:0]   rsp_idx,
    output logic [1:0]             rsp_status,
    output logic [2:0]             rsp_state,
    output logic [3*NUM_QP-1:0]    qp_state_vec,
    output logic [NUM_QP-1:0]      qp_ready_vec,
    output logic [NUM_QP-1:0]      qp_rx_en_vec,
    input  logic [IDX_WIDTH-1:0]   rd_idx,
    output logic [QPN_WIDTH-1:0]   rd_remote_qpn,
    output logic [PSN_WIDTH-1:0]   rd_sq_psn
);

    localparam int unsigned SW = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;

    typedef enum logic [2:0] {
        QP_RESET = 3'b000,
        QP_INIT  = 3'b001,
        QP_RTR   = 3'b010,
        QP_RTS   = 3'b011,
        QP_ERROR = 3'b111
    } qp_state_e;

    typedef enum logic [2:0] {
        OP_TO_INIT   = 3'd0,
        OP_TO_RTR    = 3'd1,
        OP_TO_RTS    = 3'd2,
        OP_TO_RESET  = 3'd3,
        OP_TO_ERROR  = 3'd4,
        OP_RETRY_EVT = 3'd5,
        OP_ACK_EVT   = 3'd6,
        OP_RSVD      = 3'd7
    } qp_op_e;

    typedef enum logic [1:0] {
        RSP_OK        = 2'b00,
        RSP_ILLEGAL   = 2'b01,
        RSP_BAD_IDX   = 2'b10,
        RSP_RETRY_EXC = 2'b11
    } rsp_status_e;

    qp_state_e              state_q [NUM_QP];
    qp_state_e              state_d [NUM_QP];
    logic [QPN_WIDTH-1:0]   lqpn_q  [NUM_QP];
    logic [QPN_WIDTH-1:0]   lqpn_d  [NUM_QP];
    logic [QPN_WIDTH-1:0]   rqpn_q  [NUM_QP];
    logic [QPN_WIDTH-1:0]   rqpn_d  [NUM_QP];
    logic [PSN_WIDTH-1:0]   psn_q   [NUM_QP];
    logic [PSN_WIDTH-1:0]   psn_d   [NUM_QP];
    logic [RETRY_WIDTH-1:0] retry_q [NUM_QP];
    logic [RETRY_WIDTH-1:0] retry_d [NUM_QP];

    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDX_WIDTH-1:0]   rsp_idx_q, rsp_idx_d;
    rsp_status_e            rsp_status_q, rsp_status_d;
    qp_state_e              rsp_state_q, rsp_state_d;

    logic                   cmd_accept;
    logic                   cmd_idx_ok;
    logic [SW-1:0]          cmd_slot;
    qp_state_e              cur_state;
    logic                   rd_ok;
    logic [SW-1:0]          rd_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_QP; i++) begin
                state_q[i] <= QP_RESET;
                lqpn_q[i]  <= '0;
                rqpn_q[i]  <= '0;
                psn_q[i]   <= '0;
                retry_q[i] <= '0;
            end
            rsp_valid_q  <= 1'b0;
            rsp_idx_q    <= '0;
            rsp_status_q <= RSP_OK;
            rsp_state_q  <= QP_RESET;
        end else begin
            state_q      <= state_d;
            lqpn_q       <= lqpn_d;
            rqpn_q       <= rqpn_d;
            psn_q        <= psn_d;
            retry_q      <= retry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_idx_q    <= rsp_idx_d;
            rsp_status_q <= rsp_status_d;
            rsp_state_q  <= rsp_state_d;
        end
    end

    // Only the addressed context is touched; response defaults to ILLEGAL and
    // is upgraded by whichever transition turns out to be legal.
    always_comb begin
        state_d      = state_q;
        lqpn_d       = lqpn_q;
        rqpn_d       = rqpn_q;
        psn_d        = psn_q;
        retry_d      = retry_q;
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        rsp_idx_d    = rsp_idx_q;
        rsp_status_d = rsp_status_q;
        rsp_state_d  = rsp_state_q;
        cmd_idx_ok   = 32'(cmd_idx) < NUM_QP;
        cmd_slot     = cmd_idx[SW-1:0];
        cur_state    = state_q[cmd_slot];
        if (cmd_accept) begin
            rsp_valid_d  = 1'b1;
            rsp_idx_d    = cmd_idx;
            rsp_status_d = RSP_ILLEGAL;
            rsp_state_d  = QP_RESET;
            if (!cmd_idx_ok) begin
                rsp_status_d = RSP_BAD_IDX;
            end else begin
                case (qp_op_e'(cmd_op))
                    OP_TO_INIT: if (cur_state == QP_RESET && cmd_qpn != '0) begin
                        state_d[cmd_slot] = QP_INIT;
                        lqpn_d[cmd_slot]  = cmd_qpn;
                        retry_d[cmd_slot] = '0;
                        rsp_status_d      = RSP_OK;
                    end
                    OP_TO_RTR: if (cur_state == QP_INIT && cmd_qpn != '0) begin
                        state_d[cmd_slot] = QP_RTR;
                        rqpn_d[cmd_slot]  = cmd_qpn;
                        rsp_status_d      = RSP_OK;
                    end
                    OP_TO_RTS: if (cur_state == QP_RTR) begin
                        state_d[cmd_slot] = QP_RTS;
                        psn_d[cmd_slot]   = cmd_psn;
                        retry_d[cmd_slot] = '0;
                        rsp_status_d      = RSP_OK;
                    end
                    OP_TO_RESET: begin
                        state_d[cmd_slot] = QP_RESET;
                        lqpn_d[cmd_slot]  = '0;
                        rqpn_d[cmd_slot]  = '0;
                        psn_d[cmd_slot]   = '0;
                        retry_d[cmd_slot] = '0;
                        rsp_status_d      = RSP_OK;
                    end
                    OP_TO_ERROR: begin
                        state_d[cmd_slot] = QP_ERROR;
                        rsp_status_d      = RSP_OK;
                    end
                    OP_RETRY_EVT: if (cur_state == QP_RTS) begin
                        if (retry_q[cmd_slot] == RETRY_WIDTH'(MAX_RETRY - 1)) begin
                            state_d[cmd_slot] = QP_ERROR;
                            rsp_status_d      = RSP_RETRY_EXC;
                        end else begin
                            retry_d[cmd_slot] = retry_q[cmd_slot] + RETRY_WIDTH'(1);
                            rsp_status_d      = RSP_OK;
                        end
                    end
                    OP_ACK_EVT: if (cur_state == QP_RTS) begin
                        retry_d[cmd_slot] = '0;
                        psn_d[cmd_slot]   = psn_q[cmd_slot] + PSN_WIDTH'(1);
                        rsp_status_d      = RSP_OK;
                    end
                    default: ;
                endcase
                rsp_state_d = state_d[cmd_slot];
            end
        end
    end

    always_comb begin
        cmd_ready     = !rsp_valid_q || rsp_ready;
        cmd_accept    = cmd_valid && cmd_ready;
        rsp_valid     = rsp_valid_q;
        rsp_idx       = rsp_idx_q;
        rsp_status    = rsp_status_q;
        rsp_state     = rsp_state_q;
        qp_state_vec  = '0;
        qp_ready_vec  = '0;
        qp_rx_en_vec  = '0;
        for (int unsigned i = 0; i < NUM_QP; i++) begin
            qp_state_vec[3*i +: 3] = state_q[i];
            qp_ready_vec[i]        = state_q[i] == QP_RTS;
            qp_rx_en_vec[i]        = state_q[i] == QP_RTS || state_q[i] == QP_RTR;
        end
        rd_ok         = 32'(rd_idx) < NUM_QP;
        rd_slot       = rd_idx[SW-1:0];
        rd_remote_qpn = rd_ok ? rqpn_q[rd_slot] : '0;
        rd_sq_psn     = rd_ok ? psn_q[rd_slot] : '0;
    end

endmodule

// File: tb/tb_rdma_rc_qp_ctx_mgr.sv
// Directed bench for rdma_rc_qp_ctx_mgr; IDX_WIDTH widened to 4 so that
// out-of-range indices can be driven.
module tb_rdma_rc_qp_ctx_mgr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_idx;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_qpn;
    logic [23:0] cmd_psn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_idx;
    logic [1:0]  rsp_status;
    logic [2:0]  rsp_state;
    logic [23:0] qp_state_vec;
    logic [7:0]  qp_ready_vec;
    logic [7:0]  qp_rx_en_vec;
    logic [3:0]  rd_idx;
    logic [15:0] rd_remote_qpn;
    logic [23:0] rd_sq_psn;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rdma_rc_qp_ctx_mgr #(
        .NUM_QP(8), .IDX_WIDTH(4), .QPN_WIDTH(16),
        .PSN_WIDTH(24), .MAX_RETRY(7), .RETRY_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx),
        .cmd_op(cmd_op), .cmd_qpn(cmd_qpn), .cmd_psn(cmd_psn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
        .rsp_status(rsp_status), .rsp_state(rsp_state),
        .qp_state_vec(qp_state_vec), .qp_ready_vec(qp_ready_vec),
        .qp_rx_en_vec(qp_rx_en_vec), .rd_idx(rd_idx),
        .rd_remote_qpn(rd_remote_qpn), .rd_sq_psn(rd_sq_psn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one command and step to 1 time unit after the edge that accepts it.
    task automatic send(input logic [3:0] idx, input logic [2:0] op,
                        input logic [15:0] qpn, input logic [23:0] psn);
        int unsigned n = 0;
        cmd_idx = idx; cmd_op = op; cmd_qpn = qpn; cmd_psn = psn; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic rsp_is(input string tag, input logic [3:0] idx,
                          input logic [1:0] st, input logic [2:0] s);
        check(tag, {22'd0, rsp_valid, rsp_idx, rsp_status, rsp_state},
                   {22'd0, 1'b1, idx, st, s});
    endtask

    task automatic op(input string tag, input logic [3:0] idx, input logic [2:0] o,
                      input logic [15:0] qpn, input logic [23:0] psn,
                      input logic [1:0] st, input logic [2:0] s);
        send(idx, o, qpn, psn);
        rsp_is(tag, idx, st, s);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1; cmd_valid = 1'b0;
        cmd_idx = '0; cmd_op = '0; cmd_qpn = '0; cmd_psn = '0; rd_idx = '0;
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_state_vec", 32'(qp_state_vec), 32'd0);
        check("rst_ready_vec", 32'(qp_ready_vec), 32'd0);
        check("rst_rx_en_vec", 32'(qp_rx_en_vec), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // QP3 bring-up, back-to-back
        op("qp3_init", 4'd3, 3'd0, 16'h0011, 24'h0, 2'b00, 3'b001);
        op("qp3_rtr",  4'd3, 3'd1, 16'h0042, 24'h0, 2'b00, 3'b010);
        op("qp3_rts",  4'd3, 3'd2, 16'h0000, 24'h000100, 2'b00, 3'b011);
        check("up_ready_vec", 32'(qp_ready_vec), 32'h08);
        check("up_rx_en_vec", 32'(qp_rx_en_vec), 32'h08);
        check("up_state_vec", 32'(qp_state_vec), 32'h000600);
        rd_idx = 4'd3; #1;
        check("up_rd_rqpn", 32'(rd_remote_qpn), 32'h0042);
        check("up_rd_psn",  32'(rd_sq_psn), 32'h000100);

        // Illegal transitions and bad index
        op("ill_rts_reset", 4'd0, 3'd2, 16'h0, 24'h5, 2'b01, 3'b000);
        op("qp1_init",      4'd1, 3'd0, 16'h0021, 24'h0, 2'b00, 3'b001);
        op("ill_rtr_qpn0",  4'd1, 3'd1, 16'h0000, 24'h0, 2'b01, 3'b001);
        op("ill_op7",       4'd2, 3'd7, 16'h0033, 24'h0, 2'b01, 3'b000);
        op("bad_idx",       4'd8, 3'd0, 16'h0044, 24'h0, 2'b10, 3'b000);
        check("ill_state_vec", 32'(qp_state_vec), 32'h000608);
        check("ill_ready_vec", 32'(qp_ready_vec), 32'h08);
        check("ill_rx_en_vec", 32'(qp_rx_en_vec), 32'h08);
        rd_idx = 4'd9; #1;
        check("oor_rd_rqpn", 32'(rd_remote_qpn), 32'h0);
        check("oor_rd_psn",  32'(rd_sq_psn), 32'h0);
        rd_idx = 4'd3;

        // Retry exhaustion on QP3
        for (int i = 0; i < 6; i++) op("retry_ok", 4'd3, 3'd5, 16'h0, 24'h0, 2'b00, 3'b011);
        op("retry_exc", 4'd3, 3'd5, 16'h0, 24'h0, 2'b11, 3'b111);
        check("exc_ready_vec", 32'(qp_ready_vec), 32'h00);
        check("exc_state_vec", 32'(qp_state_vec), 32'h000E08);
        op("err_rts_ill", 4'd3, 3'd2, 16'h0, 24'h0, 2'b01, 3'b111);
        op("err_reset",   4'd3, 3'd3, 16'h0, 24'h0, 2'b00, 3'b000);
        #1;
        check("reset_rd_rqpn", 32'(rd_remote_qpn), 32'h0);

        // PSN wrap and retry-count clear on ACK
        op("w_init", 4'd3, 3'd0, 16'h0011, 24'h0, 2'b00, 3'b001);
        op("w_rtr",  4'd3, 3'd1, 16'h0042, 24'h0, 2'b00, 3'b010);
        op("w_rts",  4'd3, 3'd2, 16'h0, 24'hFFFFFF, 2'b00, 3'b011);
        op("w_retry1", 4'd3, 3'd5, 16'h0, 24'h0, 2'b00, 3'b011);
        op("w_retry2", 4'd3, 3'd5, 16'h0, 24'h0, 2'b00, 3'b011);
        op("w_ack",  4'd3, 3'd6, 16'h0, 24'h0, 2'b00, 3'b011);
        check("wrap_rd_psn", 32'(rd_sq_psn), 32'h000000);
        for (int i = 0; i < 6; i++) op("ack_retry_ok", 4'd3, 3'd5, 16'h0, 24'h0, 2'b00, 3'b011);
        op("ack_retry_exc", 4'd3, 3'd5, 16'h0, 24'h0, 2'b11, 3'b111);
        op("r_reset", 4'd3, 3'd3, 16'h0, 24'h0, 2'b00, 3'b000);
        op("r_init",  4'd3, 3'd0, 16'h0011, 24'h0, 2'b00, 3'b001);
        op("r_rtr",   4'd3, 3'd1, 16'h0042, 24'h0, 2'b00, 3'b010);
        op("r_rts",   4'd3, 3'd2, 16'h0, 24'h000005, 2'b00, 3'b011);
        idle_cycle();

        // Backpressure: response held, next command waits
        rsp_ready = 1'b0;
        op("bp_first", 4'd1, 3'd4, 16'h0, 24'h0, 2'b00, 3'b111);
        cmd_idx = 4'd2; cmd_op = 3'd0; cmd_qpn = 16'h0077; cmd_psn = '0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            rsp_is("bp_hold", 4'd1, 2'b00, 3'b111);
            check("bp_qp2_state", 32'(qp_state_vec[8:6]), 32'd0);
        end
        rsp_ready = 1'b1; #1;
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rsp_is("bp_next", 4'd2, 2'b00, 3'b001);
        check("bp_state_vec", 32'(qp_state_vec), 32'h000678);
        idle_cycle();

        // Async reset with a pending response
        rsp_ready = 1'b0;
        op("ar_ack", 4'd3, 3'd6, 16'h0, 24'h0, 2'b00, 3'b011);
        cmd_valid = 1'b0;
        #1;
        check("ar_pre_psn", 32'(rd_sq_psn), 32'h000006);
        #1; rst_n = 1'b0; #1;
        check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar_state_vec", 32'(qp_state_vec), 32'd0);
        check("ar_ready_vec", 32'(qp_ready_vec), 32'd0);
        check("ar_rx_en_vec", 32'(qp_rx_en_vec), 32'd0);
        check("ar_cmd_ready", 32'(cmd_ready), 32'd1);
        check("ar_rd_psn",    32'(rd_sq_psn), 32'd0);
        #3; rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
